// File: rtl/sizer_pipe.sv
// sizer_pipe: pipelined two-output NAND2 sizing network on WIDTH lanes,
// with valid/ready flow control and a saturating delivery counter.
module sizer_pipe #(
  parameter int WIDTH = 4,
  parameter int PIPE  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] nx1,
  input  logic [WIDTH-1:0] nx2,
  input  logic [WIDTH-1:0] nx3,
  input  logic [WIDTH-1:0] nx6,
  input  logic [WIDTH-1:0] nx7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] nx22,
  output logic [WIDTH-1:0] nx23,
  output logic [CNT_W-1:0] out_count
);

  logic             o_ld;
  logic             src_v;
  logic [WIDTH-1:0] src22;
  logic [WIDTH-1:0] src23;
  logic [WIDTH-1:0] l1_n0;
  logic [WIDTH-1:0] l1_n1;

  logic             ov_q;
  logic [WIDTH-1:0] n22_q;
  logic [WIDTH-1:0] n23_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign l1_n0 = ~(nx1 & nx3);
  assign l1_n1 = ~(nx3 & nx6);

  assign o_ld = !ov_q || out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (ov_q && out_ready && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q  <= 1'b0;
      n22_q <= '0;
      n23_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (o_ld)
        ov_q <= src_v;
      if (o_ld && src_v) begin
        n22_q <= src22;
        n23_q <= src23;
      end
    end
  end

  assign out_valid = ov_q;
  assign nx22      = n22_q;
  assign nx23      = n23_q;
  assign out_count = cnt_q;

  if (PIPE == 1) begin : g_p1
    logic [WIDTH-1:0] n2;
    logic [WIDTH-1:0] n3;
    assign n2       = ~(nx7 & l1_n1);
    assign n3       = ~(nx2 & l1_n1);
    assign src_v    = in_valid;
    assign src22    = ~(l1_n0 & n3);
    assign src23    = ~(n2 & n3);
    assign in_ready = o_ld;
  end else if (PIPE == 2) begin : g_p2
    logic             a_v_q;
    logic             a_ld;
    logic [WIDTH-1:0] a_n0_q;
    logic [WIDTH-1:0] a_n1_q;
    logic [WIDTH-1:0] a_x2_q;
    logic [WIDTH-1:0] a_x7_q;
    logic [WIDTH-1:0] n2;
    logic [WIDTH-1:0] n3;

    assign a_ld = !a_v_q || o_ld;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_v_q  <= 1'b0;
        a_n0_q <= '0;
        a_n1_q <= '0;
        a_x2_q <= '0;
        a_x7_q <= '0;
      end else begin
        if (a_ld)
          a_v_q <= in_valid;
        if (a_ld && in_valid) begin
          a_n0_q <= l1_n0;
          a_n1_q <= l1_n1;
          a_x2_q <= nx2;
          a_x7_q <= nx7;
        end
      end
    end

    assign n2       = ~(a_x7_q & a_n1_q);
    assign n3       = ~(a_x2_q & a_n1_q);
    assign src_v    = a_v_q;
    assign src22    = ~(a_n0_q & n3);
    assign src23    = ~(n2 & n3);
    assign in_ready = a_ld;
  end else if (PIPE == 3) begin : g_p3
    logic             a_v_q;
    logic             a_ld;
    logic [WIDTH-1:0] a_n0_q;
    logic [WIDTH-1:0] a_n1_q;
    logic [WIDTH-1:0] a_x2_q;
    logic [WIDTH-1:0] a_x7_q;
    logic             b_v_q;
    logic             b_ld;
    logic [WIDTH-1:0] b_n0_q;
    logic [WIDTH-1:0] b_n2_q;
    logic [WIDTH-1:0] b_n3_q;

    // Ready ripples back combinationally so bubbles collapse.
    assign b_ld = !b_v_q || o_ld;
    assign a_ld = !a_v_q || b_ld;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_v_q  <= 1'b0;
        a_n0_q <= '0;
        a_n1_q <= '0;
        a_x2_q <= '0;
        a_x7_q <= '0;
        b_v_q  <= 1'b0;
        b_n0_q <= '0;
        b_n2_q <= '0;
        b_n3_q <= '0;
      end else begin
        if (a_ld)
          a_v_q <= in_valid;
        if (a_ld && in_valid) begin
          a_n0_q <= l1_n0;
          a_n1_q <= l1_n1;
          a_x2_q <= nx2;
          a_x7_q <= nx7;
        end
        if (b_ld)
          b_v_q <= a_v_q;
        if (b_ld && a_v_q) begin
          b_n0_q <= a_n0_q;
          b_n2_q <= ~(a_x7_q & a_n1_q);
          b_n3_q <= ~(a_x2_q & a_n1_q);
        end
      end
    end

    assign src_v    = b_v_q;
    assign src22    = ~(b_n0_q & b_n3_q);
    assign src23    = ~(b_n2_q & b_n3_q);
    assign in_ready = a_ld;
  end else begin : g_bad
    $error("sizer_pipe: PIPE must be 1..3");
    assign src_v    = 1'b0;
    assign src22    = '0;
    assign src23    = '0;
    assign in_ready = 1'b0;
  end

endmodule

// File: tb/tb_sizer_pipe.sv
// tb_sizer_pipe: directed bench for sizer_pipe at PIPE=1,2,3
// plus a CNT_W=3 instance for counter saturation.
module tb_sizer_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] x1, x2, x3, x6, x7;

  logic [3:0] ir;
  logic [3:0] ov;
  logic [3:0] n22 [4];
  logic [3:0] n23 [4];
  logic [7:0] cnt [4];
  logic [2:0] cntc;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar p = 1; p <= 3; p++) begin : g_dut
    sizer_pipe #(.WIDTH(4), .PIPE(p), .CNT_W(8)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (ir[p]),
      .nx1      (x1),
      .nx2      (x2),
      .nx3      (x3),
      .nx6      (x6),
      .nx7      (x7),
      .out_valid(ov[p]),
      .out_ready(out_ready),
      .nx22     (n22[p]),
      .nx23     (n23[p]),
      .out_count(cnt[p])
    );
  end

  sizer_pipe #(.WIDTH(4), .PIPE(2), .CNT_W(3)) u_sat (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (ir[0]),
    .nx1      (x1),
    .nx2      (x2),
    .nx3      (x3),
    .nx6      (x6),
    .nx7      (x7),
    .out_valid(ov[0]),
    .out_ready(out_ready),
    .nx22     (n22[0]),
    .nx23     (n23[0]),
    .out_count(cntc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] a3, input logic [3:0] a6,
                       input logic [3:0] a7);
    x1 = a1; x2 = a2; x3 = a3; x6 = a6; x7 = a7;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] nref(input logic [3:0] a1,
    input logic [3:0] a2, input logic [3:0] a3,
    input logic [3:0] a6, input logic [3:0] a7);
    logic [3:0] m0, m1, m2, m3;
    m0 = ~(a1 & a3);
    m1 = ~(a3 & a6);
    m2 = ~(a7 & m1);
    m3 = ~(a2 & m1);
    return {~(m0 & m3), ~(m2 & m3)};
  endfunction

  logic       hv [4];
  logic [7:0] hr [4];
  logic [3:0] s1 [4], s2 [4], s3 [4], s6 [4], s7 [4];
  logic [7:0] sr [4];
  logic [7:0] r;
  logic       v, rdy;
  int         beats, cyc, acc, dl, ec;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    // reset state
    do_reset();
    for (int p = 0; p < 4; p++) begin
      chk("rst_ov", ov[p], 0);
      chk("rst_n22", n22[p], 0);
      chk("rst_n23", n23[p], 0);
      chk("rst_ir", ir[p], 1);
    end
    for (int p = 1; p < 4; p++) chk("rst_cnt", cnt[p], 0);
    chk("rst_cntc", cntc, 0);

    // directed beat, hand-computed result
    drive(4'b1010, 4'b1100, 4'b1110, 4'b0100, 4'b1001);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      for (int p = 1; p <= 3; p++) begin
        chk("dir_ov", ov[p], (k == p) ? 1 : 0);
        if (k == p) begin
          chk("dir_n22", n22[p], 4'b1010);
          chk("dir_n23", n23[p], 4'b1001);
        end
      end
      if (k < 4) step();
    end
    step();
    step();

    // random stream, out_ready held high
    for (int i = 0; i < 4; i++) begin
      hv[i] = 1'b0;
      hr[i] = 8'h0;
    end
    beats = 0;
    cyc = 0;
    while (beats < 1000 && cyc < 3000) begin
      v = ($urandom_range(0, 7) != 0);
      drive(4'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom));
      r = nref(x1, x2, x3, x6, x7);
      in_valid = v;
      for (int p = 1; p <= 3; p++) chk("strm_ir", ir[p], 1);
      step();
      for (int i = 3; i > 0; i--) begin
        hv[i] = hv[i-1];
        hr[i] = hr[i-1];
      end
      hv[0] = v;
      hr[0] = r;
      if (v) beats++;
      for (int p = 1; p <= 3; p++) begin
        chk("strm_ov", ov[p], hv[p-1]);
        if (hv[p-1]) chk("strm_dat", {n22[p], n23[p]}, hr[p-1]);
      end
      cyc++;
    end
    chk("strm_beats", beats, 1000);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // stall on PIPE=3
    for (int j = 0; j < 4; j++) begin
      s1[j] = 4'($urandom); s2[j] = 4'($urandom); s3[j] = 4'($urandom);
      s6[j] = 4'($urandom); s7[j] = 4'($urandom);
      sr[j] = nref(s1[j], s2[j], s3[j], s6[j], s7[j]);
    end
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      drive(s1[acc], s2[acc], s3[acc], s6[acc], s7[acc]);
      rdy = ir[3];
      step();
      if (rdy) acc++;
      if (c >= 2) begin
        chk("stall_ov", ov[3], 1);
        chk("stall_hold", {n22[3], n23[3]}, sr[0]);
      end
    end
    chk("stall_acc", acc, 3);
    chk("stall_ir", ir[3], 0);
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rel_ov", ov[3], 1);
      chk("rel_dat", {n22[3], n23[3]}, sr[k]);
      step();
    end
    chk("rel_empty", ov[3], 0);
    for (int i = 0; i < 4; i++) step();

    // async reset with two beats in flight
    drive(4'b0011, 4'b0101, 4'b0110, 4'b1111, 4'b1000);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("fl_ov2", ov[2], 1);
    chk("fl_ov3", ov[3], 0);
    #1 rst = 1'b1;
    #1;
    for (int p = 0; p < 4; p++) chk("arst_ov", ov[p], 0);
    for (int p = 1; p < 4; p++) chk("arst_cnt", cnt[p], 0);
    chk("arst_n22", n22[2], 0);
    step();
    rst = 1'b0;
    drive(4'b1010, 4'b1100, 4'b1110, 4'b0100, 4'b1001);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("post_ov", ov[3], (k == 3) ? 1 : 0);
      if (k < 3) step();
    end
    chk("post_dat", {n22[3], n23[3]}, 8'b1010_1001);

    // counter saturation, CNT_W=3
    do_reset();
    chk("sat_start", cntc, 0);
    for (int n = 1; n <= 14; n++) begin
      in_valid = (n <= 9);
      step();
      dl = n - 2;
      if (dl < 0) dl = 0;
      if (dl > 9) dl = 9;
      ec = (dl > 7) ? 7 : dl;
      chk("sat_cnt", cntc, ec);
    end
    chk("cnt8_ok", cnt[2], 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
